uart_tx_arbiter: RTL and testbench

Shares the single TX channel of uart_core between N_REQ byte-stream requesters, e.g. the CPU console path and a hardware trace/debug streamer. Packet-atomic round-robin: a granted requester keeps the channel until it sends a byte flagged last, or until it stays idle too long. Sits between the requesters and uart_core's tx_data/data_write_en/tx_ready/tx_en signals, alongside iob_uart in the peripheral subsystem.

---
 rtl/uart_arb_pkg.sv | 31 +++
 rtl/uart_rr_picker.sv | 29 ++
 rtl/uart_tx_arbiter.sv | 176 +++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART TX arbiter: FSM encoding, hold length
// and the round-robin search used by the picker.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_HOLD = 2'd2
  } arb_state_t;

  localparam int HOLD_CYCLES = 2;
  localparam int MAX_REQ     = 32;
  localparam int MAX_REQ_W   = 5;

  // Rotate-and-find-first: index of the first set bit of req[n-1:0] at or after
  // position start (wrapping), or -1 when nothing is set.
  function automatic int rr_first(input logic [MAX_REQ-1:0] req,
                                  input int start,
                                  input int n);
    int idx;
    rr_first = -1;
    for (int i = MAX_REQ - 1; i >= 0; i--) begin
      if (i < n) begin
        idx = start + i;
        if (idx >= n) idx = idx - n;
        if (req[idx[MAX_REQ_W-1:0]]) rr_first = idx;
      end
    end
  endfunction

endpackage

// File: rtl/uart_rr_picker.sv
// Combinational round-robin selector: one-hot next owner, searching from the
// requester after the previous owner.
module uart_rr_picker
  import uart_arb_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_valid,
  input  logic [IDX_W-1:0] last,
  output logic [N_REQ-1:0] next_grant
);

  logic [MAX_REQ-1:0] req_ext;
  int                 pick_idx;

  always_comb begin
    req_ext            = '0;
    req_ext[N_REQ-1:0] = req_valid;
    pick_idx           = rr_first(req_ext, int'(last) + 1, N_REQ);
  end

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_onehot
      assign next_grant[gi] = (pick_idx == gi);
    end
  endgenerate

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-atomic round-robin arbiter sharing uart_core's TX byte channel between
// N_REQ requesters, with an idle timeout that revokes a stalled grant.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N_REQ     = 2,
  parameter int DATA_W    = 8,
  parameter int TIMEOUT_W = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      rst_soft,
  input  logic                      tx_en,
  input  logic [TIMEOUT_W-1:0]      idle_timeout,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  input  logic [N_REQ-1:0]          req_last,
  output logic [N_REQ-1:0]          req_ready,
  input  logic                      tx_ready,
  output logic [DATA_W-1:0]         tx_data,
  output logic                      tx_write_en,
  output logic [N_REQ-1:0]          grant,
  output logic                      busy,
  output logic                      timeout_evt
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam logic [TIMEOUT_W-1:0] CNT_MAX = '1;

  arb_state_t           state_reg;
  logic [N_REQ-1:0]     grant_reg;
  logic [IDX_W-1:0]     owner_reg;
  logic [IDX_W-1:0]     last_reg;
  logic                 busy_reg;
  logic [DATA_W-1:0]    tx_data_reg;
  logic                 tx_write_en_reg;
  logic                 timeout_evt_reg;
  logic                 release_reg;
  logic [1:0]           hold_cnt_reg;
  logic [TIMEOUT_W-1:0] idle_cnt_reg;
  logic [TIMEOUT_W-1:0] idle_cnt_next;

  logic [N_REQ-1:0]     next_grant;
  logic [IDX_W-1:0]     pick_idx;
  logic [DATA_W-1:0]    req_bytes [N_REQ];
  logic                 owner_valid;
  logic                 owner_last;
  logic [DATA_W-1:0]    owner_data;
  logic                 accept;
  logic                 timeout_hit;

  uart_rr_picker #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_picker (
    .req_valid  (req_valid),
    .last       (last_reg),
    .next_grant (next_grant)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (next_grant[i]) pick_idx = IDX_W'(i);
    end
  end

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
      assign req_bytes[gi] = req_data[gi*DATA_W +: DATA_W];
      assign req_ready[gi] = accept & grant_reg[gi];
    end
  endgenerate

  assign owner_valid = req_valid[owner_reg];
  assign owner_last  = req_last[owner_reg];
  assign owner_data  = req_bytes[owner_reg];

  // A soft reset in the same cycle wins, so the byte must not look accepted.
  assign accept = (state_reg == ST_SEND) & owner_valid & tx_ready & tx_en & ~rst_soft;

  always_comb begin
    idle_cnt_next = (idle_cnt_reg == CNT_MAX) ? idle_cnt_reg
                                              : idle_cnt_reg + TIMEOUT_W'(1);
    timeout_hit   = (state_reg == ST_SEND) && !owner_valid &&
                    (idle_timeout != '0) && (idle_cnt_next == idle_timeout);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= ST_IDLE;
      grant_reg       <= '0;
      owner_reg       <= '0;
      last_reg        <= IDX_W'(N_REQ - 1);
      busy_reg        <= 1'b0;
      tx_data_reg     <= '0;
      tx_write_en_reg <= 1'b0;
      timeout_evt_reg <= 1'b0;
      release_reg     <= 1'b0;
      hold_cnt_reg    <= '0;
      idle_cnt_reg    <= '0;
    end else if (rst_soft) begin
      state_reg       <= ST_IDLE;
      grant_reg       <= '0;
      owner_reg       <= '0;
      last_reg        <= IDX_W'(N_REQ - 1);
      busy_reg        <= 1'b0;
      tx_data_reg     <= '0;
      tx_write_en_reg <= 1'b0;
      timeout_evt_reg <= 1'b0;
      release_reg     <= 1'b0;
      hold_cnt_reg    <= '0;
      idle_cnt_reg    <= '0;
    end else begin
      tx_write_en_reg <= 1'b0;
      timeout_evt_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (|req_valid) begin
            grant_reg    <= next_grant;
            owner_reg    <= pick_idx;
            busy_reg     <= 1'b1;
            idle_cnt_reg <= '0;
            state_reg    <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (accept) begin
            tx_data_reg     <= owner_data;
            tx_write_en_reg <= 1'b1;
            release_reg     <= owner_last;
            hold_cnt_reg    <= '0;
            idle_cnt_reg    <= '0;
            state_reg       <= ST_HOLD;
          end else if (owner_valid) begin
            // Backpressure keeps the owner alive.
            idle_cnt_reg <= '0;
          end else if (timeout_hit) begin
            timeout_evt_reg <= 1'b1;
            last_reg        <= owner_reg;
            grant_reg       <= '0;
            busy_reg        <= 1'b0;
            idle_cnt_reg    <= '0;
            state_reg       <= ST_IDLE;
          end else if (idle_timeout != '0) begin
            idle_cnt_reg <= idle_cnt_next;
          end
        end
        ST_HOLD: begin
          // Second hold cycle masks uart_core's late tx_ready drop.
          if (hold_cnt_reg == 2'(HOLD_CYCLES - 1)) begin
            idle_cnt_reg <= '0;
            if (release_reg) begin
              last_reg  <= owner_reg;
              grant_reg <= '0;
              busy_reg  <= 1'b0;
              state_reg <= ST_IDLE;
            end else begin
              state_reg <= ST_SEND;
            end
          end else begin
            hold_cnt_reg <= hold_cnt_reg + 2'd1;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign grant       = grant_reg;
  assign busy        = busy_reg;
  assign tx_data     = tx_data_reg;
  assign tx_write_en = tx_write_en_reg;
  assign timeout_evt = timeout_evt_reg;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized and directed bench for uart_tx_arbiter against a cycle-level
// behavioural model built on per-requester byte queues.
module tb_uart_tx_arbiter;

  localparam int N_REQ     = 2;
  localparam int DATA_W    = 8;
  localparam int TIMEOUT_W = 16;
  localparam int HOLD      = 2;
  localparam int CNT_MAXI  = 65535;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    rst_soft = 1'b0;
  logic                    tx_en = 1'b1;
  logic                    tx_ready = 1'b1;
  logic [TIMEOUT_W-1:0]    idle_timeout = '0;
  logic [N_REQ-1:0]        req_valid, req_last, req_ready, grant;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [DATA_W-1:0]       tx_data;
  logic                    tx_write_en, busy, timeout_evt;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.N_REQ(N_REQ), .DATA_W(DATA_W), .TIMEOUT_W(TIMEOUT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rst_soft     (rst_soft),
    .tx_en        (tx_en),
    .idle_timeout (idle_timeout),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_last     (req_last),
    .req_ready    (req_ready),
    .tx_ready     (tx_ready),
    .tx_data      (tx_data),
    .tx_write_en  (tx_write_en),
    .grant        (grant),
    .busy         (busy),
    .timeout_evt  (timeout_evt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Requester byte queues: {last, data}; head is presented when valid.
  logic [8:0] pq [N_REQ][$];
  int         gap_pct [N_REQ];

  // Reference model state.
  int               m_owner, m_last, m_cool, m_idle;
  bit               m_rel, m_we, m_tevt;
  logic [7:0]       m_data;
  logic [N_REQ-1:0] m_ready;

  // Observation logs.
  int               cyc = 0;
  logic [7:0]       wr_data [$];
  int               wr_cyc [$];
  int               wr_own [$];
  logic [N_REQ-1:0] gnt_log [$];
  int               gnt_cyc [$];
  logic [N_REQ-1:0] prev_grant = '0;
  int               tevt_cnt = 0;

  task automatic model_reset();
    m_owner = -1; m_last = N_REQ - 1; m_cool = 0; m_idle = 0;
    m_rel = 0; m_we = 0; m_tevt = 0; m_data = '0; m_ready = '0;
  endtask

  task automatic clr_logs();
    wr_data.delete(); wr_cyc.delete(); wr_own.delete();
    gnt_log.delete(); gnt_cyc.delete(); tevt_cnt = 0;
  endtask

  task automatic push_pkt(input int r, input int n, input logic [7:0] base);
    for (int k = 0; k < n; k++) pq[r].push_back({(k == n - 1), 8'(base + k)});
  endtask

  task automatic drive();
    for (int i = 0; i < N_REQ; i++) begin
      logic v;
      v = (pq[i].size() > 0) && ($urandom_range(99) >= gap_pct[i]);
      req_valid[i] = v;
      req_data[i*DATA_W +: DATA_W] = v ? pq[i][0][7:0] : 8'($urandom);
      req_last[i] = v ? pq[i][0][8] : 1'($urandom);
    end
  endtask

  task automatic model_step();
    m_we = 0; m_tevt = 0;
    if (rst_soft) begin
      model_reset();
      return;
    end
    if (m_owner < 0) begin
      if (req_valid != '0) begin
        for (int k = 1; k <= N_REQ; k++) begin
          int c;
          c = (m_last + k) % N_REQ;
          if (req_valid[c]) begin m_owner = c; break; end
        end
        m_idle = 0; m_cool = 0;
      end
    end else if (m_cool > 0) begin
      m_cool--;
      if (m_cool == 0) begin
        m_idle = 0;
        if (m_rel) begin m_last = m_owner; m_owner = -1; end
      end
    end else if (m_ready[m_owner]) begin
      m_we = 1; m_data = req_data[m_owner*DATA_W +: DATA_W];
      m_rel = req_last[m_owner]; m_cool = HOLD; m_idle = 0;
      void'(pq[m_owner].pop_front());
    end else if (req_valid[m_owner]) begin
      m_idle = 0;
    end else if (idle_timeout != '0) begin
      if (m_idle < CNT_MAXI) m_idle++;
      if (m_idle == int'(idle_timeout)) begin
        m_tevt = 1; m_last = m_owner; m_owner = -1; m_idle = 0;
      end
    end
  endtask

  task automatic cycle();
    logic [N_REQ-1:0] exp_g;
    drive();
    #1;
    m_ready = '0;
    if (m_owner >= 0 && m_cool == 0 && req_valid[m_owner] && tx_ready && tx_en && !rst_soft)
      m_ready[m_owner] = 1'b1;
    check("req_ready", 32'(req_ready), 32'(m_ready));
    @(posedge clk);
    cyc++;
    model_step();
    #1;
    exp_g = '0;
    if (m_owner >= 0) exp_g[m_owner] = 1'b1;
    check("grant", 32'(grant), 32'(exp_g));
    check("busy", 32'(busy), 32'(m_owner >= 0));
    check("tx_write_en", 32'(tx_write_en), 32'(m_we));
    check("timeout_evt", 32'(timeout_evt), 32'(m_tevt));
    if (m_we) check("tx_data", 32'(tx_data), 32'(m_data));
    if (tx_write_en) begin
      int o;
      o = -1;
      for (int i = 0; i < N_REQ; i++) if (grant[i]) o = i;
      wr_data.push_back(tx_data); wr_cyc.push_back(cyc); wr_own.push_back(o);
      $display("[TB] cyc=%0d write req=%0d data=%02h", cyc, o, tx_data);
    end
    if (timeout_evt) tevt_cnt++;
    if (grant != prev_grant) begin
      gnt_log.push_back(grant); gnt_cyc.push_back(cyc);
      prev_grant = grant;
    end
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < N_REQ; i++) if (pq[i].size() != 0) return 0;
    return 1;
  endfunction

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while ((!all_empty() || m_owner >= 0) && n < budget) begin cycle(); n++; end
    check(tag, 32'(n < budget), 32'd1);
  endtask

  task automatic run_until_write(input string tag, input int budget);
    int n, s;
    n = 0; s = wr_data.size();
    while (wr_data.size() == s && n < budget) begin cycle(); n++; end
    check(tag, 32'(n < budget), 32'd1);
  endtask

  // Called just after a sampling point; pulls rst_n low between edges.
  task automatic async_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    check({tag, "_grant"}, 32'(grant), 32'd0);
    check({tag, "_we"}, 32'(tx_write_en), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    req_valid = '0;
    model_reset();
    for (int i = 0; i < N_REQ; i++) pq[i].delete();
    prev_grant = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    req_valid = '0; req_data = '0; req_last = '0;
    for (int i = 0; i < N_REQ; i++) gap_pct[i] = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    req_valid = '1;
    #1;
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_we", 32'(tx_write_en), 32'd0);
    check("rst_data", 32'(tx_data), 32'd0);
    check("rst_tevt", 32'(timeout_evt), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: single requester, three-byte packet.
    clr_logs();
    push_pkt(0, 3, 8'h41);
    drain("t1_drain", 40);
    check("t1_count", 32'(wr_data.size()), 32'd3);
    if (wr_data.size() == 3) begin
      for (int k = 0; k < 3; k++) check("t1_data", 32'(wr_data[k]), 32'(8'h41 + k));
      check("t1_gap01", 32'(wr_cyc[1] - wr_cyc[0]), 32'd3);
      check("t1_gap12", 32'(wr_cyc[2] - wr_cyc[1]), 32'd3);
      check("t1_release", 32'(gnt_cyc[gnt_cyc.size()-1] - wr_cyc[2]), 32'd2);
    end

    // 2: both pending after reset, no interleave.
    async_reset("t2_rst");
    clr_logs();
    push_pkt(0, 2, 8'h10);
    push_pkt(1, 2, 8'h20);
    drain("t2_drain", 60);
    check("t2_count", 32'(wr_data.size()), 32'd4);
    if (wr_data.size() == 4) begin
      check("t2_d0", 32'(wr_data[0]), 32'h10);
      check("t2_d1", 32'(wr_data[1]), 32'h11);
      check("t2_d2", 32'(wr_data[2]), 32'h20);
      check("t2_d3", 32'(wr_data[3]), 32'h21);
    end
    check("t2_glog_n", 32'(gnt_log.size()), 32'd4);
    if (gnt_log.size() == 4) begin
      check("t2_g0", 32'(gnt_log[0]), 32'b01);
      check("t2_g1", 32'(gnt_log[1]), 32'b00);
      check("t2_g2", 32'(gnt_log[2]), 32'b10);
      check("t2_g3", 32'(gnt_log[3]), 32'b00);
    end

    // 3: alternating single-byte packets.
    clr_logs();
    for (int k = 0; k < 3; k++) begin
      push_pkt(0, 1, 8'(8'h30 + k));
      push_pkt(1, 1, 8'(8'h60 + k));
    end
    drain("t3_drain", 100);
    check("t3_count", 32'(wr_data.size()), 32'd6);
    for (int k = 0; k < wr_own.size(); k++) check("t3_owner", 32'(wr_own[k]), 32'(k % 2));

    // 4: backpressure never times out.
    clr_logs();
    idle_timeout = 16'd10;
    tx_ready = 1'b0;
    push_pkt(0, 1, 8'h77);
    repeat (50) cycle();
    check("t4_no_write", 32'(wr_data.size()), 32'd0);
    check("t4_no_tevt", 32'(tevt_cnt), 32'd0);
    check("t4_grant", 32'(grant), 32'b01);
    tx_ready = 1'b1;
    cycle();
    check("t4_we", 32'(tx_write_en), 32'd1);
    check("t4_data", 32'(tx_data), 32'h77);
    drain("t4_drain", 20);

    // 5: idle timeout abandons req1's partial packet.
    clr_logs();
    pq[1].push_back({1'b0, 8'h55});
    push_pkt(0, 1, 8'h66);
    begin
      int n;
      n = 0;
      while (n < 40) begin
        cycle(); n++;
        if (timeout_evt) break;
      end
      check("t5_tevt_seen", 32'(n < 40), 32'd1);
    end
    check("t5_owner", 32'(wr_own.size() > 0 ? wr_own[0] : -1), 32'd1);
    if (wr_cyc.size() > 0) check("t5_delay", 32'(cyc - wr_cyc[0]), 32'd12);
    check("t5_grant0", 32'(grant), 32'd0);
    cycle();
    check("t5_regrant", 32'(grant), 32'b01);
    drain("t5_drain", 30);
    idle_timeout = '0;

    // 6a: async reset mid-packet, then req0 wins.
    clr_logs();
    push_pkt(1, 3, 8'h80);
    run_until_write("t6_wr", 20);
    async_reset("t6_rst");
    push_pkt(0, 1, 8'h90);
    push_pkt(1, 1, 8'hA0);
    cycle();
    check("t6_first", 32'(grant), 32'b01);
    drain("t6_drain", 40);

    // 6b: soft reset mid-packet takes effect one edge later.
    push_pkt(1, 3, 8'hB0);
    run_until_write("t6s_wr", 20);
    rst_soft = 1'b1;
    #1;
    check("t6s_pre", 32'(grant), 32'b10);
    cycle();
    check("t6s_grant", 32'(grant), 32'd0);
    check("t6s_busy", 32'(busy), 32'd0);
    check("t6s_we", 32'(tx_write_en), 32'd0);
    rst_soft = 1'b0;
    for (int i = 0; i < N_REQ; i++) pq[i].delete();
    push_pkt(0, 1, 8'hC0);
    push_pkt(1, 1, 8'hD0);
    cycle();
    check("t6s_first", 32'(grant), 32'b01);
    drain("t6s_drain", 40);

    // Randomized traffic.
    for (int c = 0; c < 1500; c++) begin
      if (c % 250 == 0) begin
        idle_timeout = 16'($urandom_range(0, 3) * 4);
        for (int i = 0; i < N_REQ; i++) gap_pct[i] = $urandom_range(0, 50);
      end
      tx_ready = ($urandom_range(0, 3) != 0);
      tx_en    = ($urandom_range(0, 15) != 0);
      rst_soft = ($urandom_range(0, 499) == 0);
      for (int i = 0; i < N_REQ; i++)
        if (pq[i].size() < 2) push_pkt(i, $urandom_range(1, 4), 8'($urandom));
      cycle();
    end
    rst_soft = 1'b0; tx_ready = 1'b1; tx_en = 1'b1; idle_timeout = '0;
    for (int i = 0; i < N_REQ; i++) gap_pct[i] = 0;
    drain("rand_drain", 200);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
